matrix_transpose_seq: RTL
=========================

Name: matrix_transpose_seq

Overview:
Sequencer that drives one matrix_transpose_top instance from a single-element stream interface.
- LOAD: writes an incoming valid/ready element stream row-major into the core input array.
- KICK: pulses the core ctrl input.
- WAIT: waits for the core out_val, guarded by a timeout.
- DRAIN: streams the transposed output array back out row-major.

It replaces ad-hoc select driving of the core's element arrays and sits between the host/DMA stream and the transpose core.

Parameters:
- DATA_WIDTH, 64: element width.
- NUM_MG, 16: matrix rows (row index range); must be ≥2.
- NUM_PE, NUM_MG: matrix columns (column index range); must be ≥2.
- TIMEOUT_CYCLES, 4096: maximum cycles spent in WAIT before abort; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; honoured only in IDLE.
- in_valid  in  1  input element valid.
- in_ready  out  1  controller accepts an input element.
- in_data  in  DATA_WIDTH  input element.
- wr_en  out  1  write strobe to the core input array.
- wr_i  out  $clog2(NUM_MG)  input-array row select.
- wr_j  out  $clog2(NUM_PE)  input-array column select.
- wr_data  out  DATA_WIDTH  data written to the input array.
- core_ctrl  out  1  one-cycle start pulse to the core.
- core_out_val  in  1  core result valid.
- rd_i  out  $clog2(NUM_MG)  output-array row select.
- rd_j  out  $clog2(NUM_PE)  output-array column select.
- rd_data  in  DATA_WIDTH  combinational mux of the output array at [rd_i][rd_j].
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts the output element.
- out_data  out  DATA_WIDTH  output element.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the last output beat is accepted.
- err_timeout  out  1  sticky flag set on WAIT timeout.

Behaviour:
- States: IDLE, LOAD, KICK, WAIT, DRAIN. Row/column counters (ri, cj) and a timeout counter are registered.
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; ri, cj and the timeout counter clear to 0; err_timeout clears to 0.
  - All outputs read 0 while in IDLE after reset.
  - Reset mid-job abandons the job with no done pulse; the core shares rst.
- IDLE:
  - in_ready=0, out_valid=0, wr_en=0.
  - start=1 → LOAD; ri, cj cleared; err_timeout cleared.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1. wr_en = in_valid; wr_i=ri; wr_j=cj; wr_data=in_data (combinational).
  - On each handshake (in_valid & in_ready): cj increments; at cj=NUM_PE-1 it wraps to 0 and ri increments.
  - The handshake at ri=NUM_MG-1, cj=NUM_PE-1 → KICK, with ri, cj cleared.
  - No handshake → counters hold.
  - Exactly NUM_MG*NUM_PE handshakes are accepted.
- KICK:
  - core_ctrl=1 for exactly this one cycle; timeout counter cleared → WAIT.
  - core_ctrl is 0 in every other state.
- WAIT:
  - core_out_val=1 → DRAIN, with ri, cj=0.
  - Otherwise the timeout counter increments. The cycle on which the counter equals TIMEOUT_CYCLES-1 without core_out_val → IDLE, err_timeout=1, no done pulse.
  - core_out_val on that same cycle wins: → DRAIN.
  - core_out_val seen in any state other than WAIT is ignored.
- DRAIN:
  - out_valid=1; rd_i=ri; rd_j=cj; out_data=rd_data (combinational, zero-latency mux).
  - Counters advance on out_valid & out_ready with the same row-major wrap as LOAD. Under backpressure, rd_i/rd_j and out_data hold stable.
  - The final handshake (NUM_MG-1, NUM_PE-1) → IDLE with done=1 for one cycle.
  - A start asserted on that same cycle is ignored; it must be re-asserted in IDLE.
- Outputs outside their owning state:
  - rd_i, rd_j: 0 outside DRAIN.
  - wr_i, wr_j: 0 outside LOAD.
  - wr_data, out_data: don't-care when their strobe is 0.
- busy is combinational from state.
- Throughput: 1 element/cycle on both streams with no bubbles.
- Minimum job length with no stalls and a core latency of L cycles: 2·N + L + 2 cycles, where N = NUM_MG·NUM_PE.

Test Plan:
Use NUM_MG=NUM_PE=4 and TIMEOUT_CYCLES=8.
1. Full job: start; stream 0..15 with in_valid always 1; a core model raises out_val 3 cycles after core_ctrl.
   → wr_en on 16 consecutive cycles with (wr_i,wr_j)=(0,0),(0,1)…(3,3); one core_ctrl pulse; out_data = 0,4,8,12,1,5,…,15; done pulses exactly once; busy falls the same cycle done pulses.
2. Input bubbles: in_valid toggled 1,0,1,0…
   → wr_en only on valid cycles; counters hold on bubbles; KICK entered only after the 16th accepted element.
3. Output backpressure: out_ready held low 5 cycles at element (1,2).
   → rd_i=1, rd_j=2 and out_data held stable for those 5 cycles; no element skipped or duplicated; 16 beats total.
4. Timeout: core_out_val never asserted.
   → 8 WAIT cycles, then IDLE with err_timeout=1 and no done. A following start clears err_timeout and a full job completes normally.
5. Reset mid-LOAD after 7 elements: rst=1 for one cycle.
   → next cycle busy=0, in_ready=0, err_timeout=0. A new job restarts at (0,0), and the 16 elements of the new job are written starting at (0,0).
6. start pulsed during LOAD, WAIT and on the done cycle.
   → all ignored: no counter reset, no second job, exactly one done per job.

Source files
------------

// File: rtl/matrix_transpose_seq.sv
// Stream-to-array sequencer for one matrix_transpose_top core: loads a row-major
// element stream, kicks the core, waits for its result and drains the transpose.
module matrix_transpose_seq #(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_MG         = 16,
  parameter int NUM_PE         = NUM_MG,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  // Both streams: a beat transfers on a clk edge where valid & ready are both 1;
  // the source holds data stable while valid=1 and ready=0.
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      wr_en,
  output logic [$clog2(NUM_MG)-1:0] wr_i,
  output logic [$clog2(NUM_PE)-1:0] wr_j,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      core_ctrl,
  input  logic                      core_out_val,
  output logic [$clog2(NUM_MG)-1:0] rd_i,
  output logic [$clog2(NUM_PE)-1:0] rd_j,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err_timeout,
  output logic [2:0]                state_dbg
);

  localparam int RW = $clog2(NUM_MG);
  localparam int CW = $clog2(NUM_PE);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t        state;
  logic [RW-1:0] ri;
  logic [CW-1:0] cj;
  logic [TW-1:0] tcnt;

  logic          col_last;
  logic          row_last;
  logic [RW-1:0] ri_next;
  logic [CW-1:0] cj_next;
  logic          tmo_last;

  // Row-major walk shared by LOAD and DRAIN.
  always_comb begin
    col_last = (cj == CW'(NUM_PE - 1));
    row_last = (ri == RW'(NUM_MG - 1));
    cj_next  = col_last ? '0 : cj + 1'b1;
    ri_next  = col_last ? ri + 1'b1 : ri;
    tmo_last = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ri          <= '0;
      cj          <= '0;
      tcnt        <= '0;
      err_timeout <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            ri          <= '0;
            cj          <= '0;
            err_timeout <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (row_last && col_last) begin
              state <= S_KICK;
              ri    <= '0;
              cj    <= '0;
            end else begin
              ri <= ri_next;
              cj <= cj_next;
            end
          end
        end
        S_KICK: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still wins over the abort.
          if (core_out_val) begin
            state <= S_DRAIN;
            ri    <= '0;
            cj    <= '0;
          end else if (tmo_last) begin
            state       <= S_IDLE;
            err_timeout <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (row_last && col_last) begin
              state <= S_IDLE;
              done  <= 1'b1;
              ri    <= '0;
              cj    <= '0;
            end else begin
              ri <= ri_next;
              cj <= cj_next;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stream-side outputs are decoded from the registered state so selects are
  // zero outside their owning state and data paths stay zero-latency.
  always_comb begin
    in_ready  = (state == S_LOAD);
    wr_en     = in_ready & in_valid;
    wr_i      = in_ready ? ri : '0;
    wr_j      = in_ready ? cj : '0;
    wr_data   = in_ready ? in_data : '0;
    core_ctrl = (state == S_KICK);
    out_valid = (state == S_DRAIN);
    rd_i      = out_valid ? ri : '0;
    rd_j      = out_valid ? cj : '0;
    out_data  = out_valid ? rd_data : '0;
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

endmodule
